pixel_pipeline_lane_balancer: RTL and testbench

PIXEL_PIPELINE_LANE_BALANCER -- requirements
Module: pixel_pipeline_lane_balancer

---
 rtl/pixel_pipeline_lane_balancer.sv | 136 +++++++++++++
 tb/tb_pixel_pipeline_lane_balancer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_pipeline_lane_balancer.sv
// Round-robin fragment dispatcher across parallel pixel lanes with per-lane credits
// and an in-order collector that walks the same lane sequence back to one stream.
module pixel_pipeline_lane_balancer #(
  parameter int unsigned NUM_LANES       = 4,
  parameter int unsigned USER_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                            aclk,
  input  logic                            reset,
  input  logic [NUM_LANES-1:0]            confLaneEnable,
  input  logic                            s_frag_tvalid,
  output logic                            s_frag_tready,
  input  logic [USER_WIDTH-1:0]           s_frag_tuser,
  output logic [NUM_LANES-1:0]            m_lane_tvalid,
  input  logic [NUM_LANES-1:0]            m_lane_tready,
  output logic [USER_WIDTH-1:0]           m_lane_tuser,
  input  logic [NUM_LANES-1:0]            s_lane_tvalid,
  output logic [NUM_LANES-1:0]            s_lane_tready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] s_lane_tdata,
  output logic                            m_frag_tvalid,
  input  logic                            m_frag_tready,
  output logic [DATA_WIDTH-1:0]           m_frag_tdata,
  output logic                            idle
);

  localparam int unsigned PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [PTR_W-1:0]      r_dptr;
  logic [PTR_W-1:0]      r_cptr;
  logic [CNT_W-1:0]      r_outstanding [NUM_LANES];
  logic                  r_mvalid;
  logic [DATA_WIDTH-1:0] r_mdata;
  logic                  r_idle;

  logic [NUM_LANES-1:0]  w_mask;
  logic [PTR_W-1:0]      w_low;
  logic [PTR_W-1:0]      w_dsel;
  logic [PTR_W-1:0]      w_csel;
  logic                  w_credit;
  logic                  w_dispatch;
  logic                  w_collect;
  logic                  w_mvalid_nxt;
  logic                  w_busy_nxt;
  logic [CNT_W-1:0]      w_out_nxt [NUM_LANES];
  logic [DATA_WIDTH-1:0] w_lane_data [NUM_LANES];

  function automatic logic [PTR_W-1:0] f_lowest(input logic [NUM_LANES-1:0] mask);
    logic [PTR_W-1:0] sel;
    logic             found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!found && mask[i]) begin
        sel   = PTR_W'(i);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Next enabled lane strictly above cur, else wrap to the lowest enabled lane.
  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] cur,
                                              input logic [NUM_LANES-1:0] mask);
    logic [PTR_W-1:0] sel;
    logic             found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!found && mask[i] && (PTR_W'(i) > cur)) begin
        sel   = PTR_W'(i);
        found = 1'b1;
      end
    end
    if (!found) sel = f_lowest(mask);
    return sel;
  endfunction

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_data
    assign w_lane_data[g] = s_lane_tdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign m_lane_tuser  = s_frag_tuser;
  assign m_frag_tvalid = r_mvalid;
  assign m_frag_tdata  = r_mdata;
  assign idle          = r_idle;

  // Handshake paths; while idle both pointers track the lowest enabled lane.
  always_comb begin
    w_mask        = (confLaneEnable == '0) ? NUM_LANES'(1) : confLaneEnable;
    w_low         = f_lowest(w_mask);
    w_dsel        = r_idle ? w_low : r_dptr;
    w_csel        = r_idle ? w_low : r_cptr;
    w_credit      = r_outstanding[w_dsel] < CNT_W'(MAX_OUTSTANDING);
    m_lane_tvalid = '0;
    s_lane_tready = '0;
    s_frag_tready = 1'b0;
    if (!reset) begin
      m_lane_tvalid[w_dsel] = s_frag_tvalid & w_credit;
      s_frag_tready         = m_lane_tready[w_dsel] & w_credit;
      s_lane_tready[w_csel] = ~r_mvalid | m_frag_tready;
    end
    w_dispatch   = s_frag_tvalid & s_frag_tready;
    w_collect    = s_lane_tvalid[w_csel] & s_lane_tready[w_csel];
    w_mvalid_nxt = w_collect | (r_mvalid & ~m_frag_tready);
    w_busy_nxt   = w_mvalid_nxt;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      case ({w_dispatch && (w_dsel == PTR_W'(i)), w_collect && (w_csel == PTR_W'(i))})
        2'b10:   w_out_nxt[i] = r_outstanding[i] + CNT_W'(1);
        2'b01:   w_out_nxt[i] = r_outstanding[i] - CNT_W'(1);
        default: w_out_nxt[i] = r_outstanding[i];
      endcase
      if (w_out_nxt[i] != '0) w_busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_dptr   <= '0;
      r_cptr   <= '0;
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_idle   <= 1'b1;
      for (int unsigned i = 0; i < NUM_LANES; i++) r_outstanding[i] <= '0;
    end else begin
      r_dptr   <= w_dispatch ? f_next(w_dsel, w_mask) : w_dsel;
      r_cptr   <= w_collect ? f_next(w_csel, w_mask) : w_csel;
      r_mvalid <= w_mvalid_nxt;
      if (w_collect) r_mdata <= w_lane_data[w_csel];
      r_idle   <= ~w_busy_nxt;
      for (int unsigned i = 0; i < NUM_LANES; i++) r_outstanding[i] <= w_out_nxt[i];
    end
  end

endmodule

// File: tb/tb_pixel_pipeline_lane_balancer.sv
// Directed bench: lane models with per-lane latency, a source queue and an
// output scoreboard checked in order as fragments leave the balancer.
module tb_pixel_pipeline_lane_balancer;

  localparam int NL = 4;
  localparam int UW = 16;
  localparam int DW = 16;
  localparam int MO = 2;
  localparam int LB = 16;

  logic             aclk;
  logic             reset;
  logic [NL-1:0]    confLaneEnable;
  logic             s_frag_tvalid;
  logic             s_frag_tready;
  logic [UW-1:0]    s_frag_tuser;
  logic [NL-1:0]    m_lane_tvalid;
  logic [NL-1:0]    m_lane_tready;
  logic [UW-1:0]    m_lane_tuser;
  logic [NL-1:0]    s_lane_tvalid;
  logic [NL-1:0]    s_lane_tready;
  logic [NL*DW-1:0] s_lane_tdata;
  logic             m_frag_tvalid;
  logic             m_frag_tready;
  logic [DW-1:0]    m_frag_tdata;
  logic             idle;

  pixel_pipeline_lane_balancer #(
    .NUM_LANES(NL), .USER_WIDTH(UW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .aclk(aclk), .reset(reset), .confLaneEnable(confLaneEnable),
    .s_frag_tvalid(s_frag_tvalid), .s_frag_tready(s_frag_tready), .s_frag_tuser(s_frag_tuser),
    .m_lane_tvalid(m_lane_tvalid), .m_lane_tready(m_lane_tready), .m_lane_tuser(m_lane_tuser),
    .s_lane_tvalid(s_lane_tvalid), .s_lane_tready(s_lane_tready), .s_lane_tdata(s_lane_tdata),
    .m_frag_tvalid(m_frag_tvalid), .m_frag_tready(m_frag_tready), .m_frag_tdata(m_frag_tdata),
    .idle(idle)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accepted = 0;
  int outputs = 0;
  bit out_rdy = 1'b1;

  int lat  [NL];
  bit hold [NL];
  int l_tag [NL][LB];
  int l_due [NL][LB];
  int l_head [NL];
  int l_cnt  [NL];

  int            src_q [$];
  logic [DW-1:0] exp_q [$];
  int            dlog  [$];

  function automatic logic [DW-1:0] lane_fn(input int tag);
    return DW'(tag * 7 + 32'h1234);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_mask(input logic [NL-1:0] m);
    chk("mask_change_while_idle", 32'(idle), 32'd1);
    confLaneEnable = m;
  endtask

  task automatic set_lat(input int a, input int b, input int c, input int d);
    lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
  endtask

  // One cycle: drive at negedge, observe settled handshakes just before posedge.
  task automatic tick();
    int nhs;
    int lane;
    int idx;
    s_frag_tvalid = (src_q.size() > 0);
    s_frag_tuser  = (src_q.size() > 0) ? UW'(src_q[0]) : '0;
    m_frag_tready = out_rdy;
    for (int i = 0; i < NL; i++) begin
      s_lane_tvalid[i] = 1'b0;
      s_lane_tdata[i*DW +: DW] = '0;
      if (!hold[i] && l_cnt[i] > 0 && l_due[i][l_head[i]] <= cyc) begin
        s_lane_tvalid[i] = 1'b1;
        s_lane_tdata[i*DW +: DW] = lane_fn(l_tag[i][l_head[i]]);
      end
    end
    #1;
    if (s_frag_tvalid && s_frag_tready) begin
      nhs  = 0;
      lane = 0;
      for (int i = 0; i < NL; i++)
        if (m_lane_tvalid[i] && m_lane_tready[i]) begin
          nhs++;
          lane = i;
        end
      chk("dispatch_onehot", 32'(nhs), 32'd1);
      idx = (l_head[lane] + l_cnt[lane]) % LB;
      l_tag[lane][idx] = int'(m_lane_tuser);
      l_due[lane][idx] = cyc + lat[lane];
      l_cnt[lane]++;
      dlog.push_back(lane);
      exp_q.push_back(lane_fn(src_q.pop_front()));
      accepted++;
    end
    for (int i = 0; i < NL; i++)
      if (s_lane_tvalid[i] && s_lane_tready[i]) begin
        l_head[i] = (l_head[i] + 1) % LB;
        l_cnt[i]--;
      end
    if (m_frag_tvalid && m_frag_tready) begin
      outputs++;
      if (exp_q.size() == 0) chk("spurious_output", 32'(m_frag_tdata), 32'hFFFF_FFFF);
      else chk("output_order_data", 32'(m_frag_tdata), 32'(exp_q.pop_front()));
    end
    @(negedge aclk);
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (src_q.size() == 0 && exp_q.size() == 0 && idle === 1'b1) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic clear_models();
    for (int i = 0; i < NL; i++) begin
      l_head[i] = 0;
      l_cnt[i]  = 0;
      hold[i]   = 1'b0;
    end
    src_q.delete();
    exp_q.delete();
    dlog.delete();
  endtask

  initial begin
    int base;
    int nz;
    int exp_l [6];
    exp_l = '{1, 3, 1, 3, 1, 3};
    clear_models();
    set_lat(1, 1, 1, 1);
    reset          = 1'b1;
    confLaneEnable = 4'hF;
    s_frag_tvalid  = 1'b1;
    s_frag_tuser   = 16'h0055;
    m_lane_tready  = '1;
    s_lane_tvalid  = '1;
    s_lane_tdata   = '1;
    m_frag_tready  = 1'b1;
    repeat (3) @(negedge aclk);

    // Reset state with live-looking inputs
    chk("rst_m_frag_tvalid", 32'(m_frag_tvalid), 32'd0);
    chk("rst_m_frag_tdata", 32'(m_frag_tdata), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_m_lane_tvalid", 32'(m_lane_tvalid), 32'd0);
    chk("rst_s_lane_tready", 32'(s_lane_tready), 32'd0);
    chk("rst_s_frag_tready", 32'(s_frag_tready), 32'd0);
    s_frag_tvalid = 1'b0;
    s_lane_tvalid = '0;
    s_lane_tdata  = '0;
    reset = 1'b0;
    @(negedge aclk);

    // Stream order across all four lanes with unequal latencies
    set_lat(3, 7, 1, 12);
    base = outputs;
    for (int t = 0; t < 100; t++) src_q.push_back(t);
    drain("stream_drain", 4000);
    chk("stream_count", 32'(outputs - base), 32'd100);
    chk("stream_idle_end", 32'(idle), 32'd1);

    // Lane skipping with a sparse mask
    set_mask(4'b1010);
    set_lat(2, 2, 2, 2);
    dlog.delete();
    for (int t = 100; t < 106; t++) src_q.push_back(t);
    drain("skip_drain", 500);
    chk("skip_dispatch_count", 32'(dlog.size()), 32'd6);
    for (int k = 0; k < 6 && k < dlog.size(); k++) chk("skip_dispatch_lane", 32'(dlog[k]), 32'(exp_l[k]));

    // Credit limit on a single lane that never returns
    set_mask(4'b0001);
    set_lat(1, 1, 1, 1);
    hold[0] = 1'b1;
    base = accepted;
    for (int t = 200; t < 205; t++) src_q.push_back(t);
    repeat (10) tick();
    chk("credit_accepted", 32'(accepted - base), 32'd2);
    chk("credit_stall_tready", 32'(s_frag_tready), 32'd0);
    hold[0] = 1'b0;
    tick();
    chk("credit_resume_tready", 32'(s_frag_tready), 32'd1);
    drain("credit_drain", 500);

    // Output backpressure with continuous input
    set_mask(4'b1111);
    out_rdy = 1'b0;
    base = accepted;
    for (int t = 300; t < 340; t++) src_q.push_back(t);
    repeat (50) tick();
    chk("bp_accepted", 32'(accepted - base), 32'(NL * MO + 1));
    chk("bp_out_valid_held", 32'(m_frag_tvalid), 32'd1);
    out_rdy = 1'b1;
    drain("bp_drain", 1000);

    // Zero mask maps to lane 0; dispatch and collect overlap every cycle
    set_mask(4'b0000);
    dlog.delete();
    base = accepted;
    for (int t = 400; t < 420; t++) src_q.push_back(t);
    repeat (21) tick();
    chk("overlap_accepted", 32'(accepted - base), 32'd20);
    nz = 0;
    foreach (dlog[k]) if (dlog[k] != 0) nz++;
    chk("zero_mask_lane0_only", 32'(nz), 32'd0);
    drain("overlap_drain", 500);

    // Reset with five fragments in flight
    set_mask(4'b1111);
    set_lat(1, 30, 30, 30);
    out_rdy = 1'b0;
    for (int t = 500; t < 505; t++) src_q.push_back(t);
    repeat (6) tick();
    chk("pre_reset_out_valid", 32'(m_frag_tvalid), 32'd1);
    chk("pre_reset_busy", 32'(idle), 32'd0);
    reset = 1'b1;
    #1;
    chk("midrst_m_frag_tvalid", 32'(m_frag_tvalid), 32'd0);
    chk("midrst_idle", 32'(idle), 32'd1);
    chk("midrst_s_frag_tready", 32'(s_frag_tready), 32'd0);
    clear_models();
    s_frag_tvalid = 1'b0;
    s_lane_tvalid = '0;
    out_rdy = 1'b1;
    @(negedge aclk);
    reset = 1'b0;
    @(negedge aclk);
    chk("postrst_idle", 32'(idle), 32'd1);
    // Full credit on every lane shows the counters restarted at zero
    set_lat(30, 30, 30, 30);
    base = accepted;
    for (int t = 600; t < 610; t++) src_q.push_back(t);
    repeat (10) tick();
    chk("postrst_full_credit", 32'(accepted - base), 32'(NL * MO));
    drain("postrst_drain", 500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
